// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST engine: state encoding, width helpers
// and the reference sum used by the checker.
package adder_bist_pkg;

    localparam int unsigned MAX_N = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_CHECK  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    function automatic int unsigned vec_w(input int unsigned n);
        return 2 * n + 1;
    endfunction

    function automatic int unsigned sum_w(input int unsigned n);
        return n + 1;
    endfunction

    // Full-width a+b+cin; callers keep the low N+1 bits, which hold the whole result.
    function automatic logic [MAX_N:0] golden_sum(input logic [MAX_N-1:0] a,
                                                  input logic [MAX_N-1:0] b,
                                                  input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{MAX_N{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/adder_bist_vecgen.sv
// Vector index and settle counters for the adder BIST; drives the adder operands
// straight from the registered index, ordered {cin, a, b}.
module adder_bist_vecgen
    import adder_bist_pkg::*;
#(
    parameter int unsigned N             = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         idx_clear,
    input  logic         idx_inc,
    input  logic         wait_clear,
    input  logic         wait_inc,
    output logic [2*N:0] idx,
    output logic         last_vec_c,
    output logic         settle_done_c,
    output logic [N-1:0] dut_a,
    output logic [N-1:0] dut_b,
    output logic         dut_cin
);

    localparam int unsigned VEC_W  = vec_w(N);
    localparam int unsigned WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            wait_cnt <= '0;
        end else begin
            if (idx_clear) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + VEC_W'(1);
            end
            if (wait_clear) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    assign last_vec_c    = &idx;
    assign settle_done_c = (wait_cnt == WAIT_W'(SETTLE_CYCLES - 1));

    assign dut_b   = idx[N-1:0];
    assign dut_a   = idx[2*N-1:N];
    assign dut_cin = idx[2*N];

endmodule

// File: rtl/adder_bist_controller.sv
// Exhaustive on-chip self-test for an N-bit adder with carry-in: sweeps every
// {cin,a,b} vector, checks {cout,S} against a+b+cin and reports the verdict.
module adder_bist_controller
    import adder_bist_pkg::*;
#(
    parameter int unsigned N             = 4,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N-1:0]     dut_a,
    output logic [N-1:0]     dut_b,
    output logic             dut_cin,
    input  logic [N-1:0]     dut_s,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [2*N:0]     first_fail_vec
);

    localparam int unsigned SUM_W = sum_w(N);

    state_t             state, state_d;
    logic [ERR_W-1:0]   err_d;
    logic               ffv_d;
    logic [2*N:0]       ffvec_d;
    logic               busy_d, done_d, pass_d;
    logic               idx_clear, idx_inc, wait_clear, wait_inc;
    logic [2*N:0]       idx;
    logic               last_vec_c, settle_done_c;
    logic [SUM_W-1:0]   golden;
    logic               mismatch;

    adder_bist_vecgen #(
        .N             (N),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_vecgen (
        .clk           (clk),
        .rst           (rst),
        .idx_clear     (idx_clear),
        .idx_inc       (idx_inc),
        .wait_clear    (wait_clear),
        .wait_inc      (wait_inc),
        .idx           (idx),
        .last_vec_c    (last_vec_c),
        .settle_done_c (settle_done_c),
        .dut_a         (dut_a),
        .dut_b         (dut_b),
        .dut_cin       (dut_cin)
    );

    assign golden   = SUM_W'(golden_sum(MAX_N'(dut_a), MAX_N'(dut_b), dut_cin));
    assign mismatch = ({dut_cout, dut_s} != golden);

    // Next-state, counter controls and next values of the report registers.
    always_comb begin
        state_d    = state;
        err_d      = err_count;
        ffv_d      = first_fail_valid;
        ffvec_d    = first_fail_vec;
        idx_clear  = 1'b0;
        idx_inc    = 1'b0;
        wait_clear = 1'b0;
        wait_inc   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    idx_clear  = 1'b1;
                    wait_clear = 1'b1;
                    err_d      = '0;
                    ffv_d      = 1'b0;
                    ffvec_d    = '0;
                end
            end
            ST_SETTLE: begin
                wait_inc = 1'b1;
                if (settle_done_c) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (!(&err_count)) begin
                        err_d = err_count + ERR_W'(1);
                    end
                    if (!first_fail_valid) begin
                        ffv_d   = 1'b1;
                        ffvec_d = idx;
                    end
                end
                if (last_vec_c) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_SETTLE;
                    idx_inc    = 1'b1;
                    wait_clear = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags follow the next state so they line up with the state register.
    assign busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    assign done_d = (state_d == ST_DONE);
    assign pass_d = (state_d == ST_DONE) && (err_d == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
        end else begin
            state            <= state_d;
            err_count        <= err_d;
            first_fail_valid <= ffv_d;
            first_fail_vec   <= ffvec_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
        end
    end

endmodule
